spi_req_arbiter: RTL and testbench
==================================

Name: spi_req_arbiter

Overview:
Shares one byte-wide SPI master between NUM_REQ requesters using round-robin arbitration. For each granted requester it latches the byte, issues a one-cycle start to the master, and waits for completion or timeout. It then enforces a minimum chip-select idle gap before the next grant. It sits between system-side requesters and the SPI master FSM and also drives per-slave select.

Parameters:
NUM_REQ, 4, number of requesters and slaves (2..8)
GAP_CYC, 4, idle cycles between transactions, minimum 1
TIMEOUT_CYC, 255, cycles allowed in WAIT_DONE before abort

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_i  in  NUM_REQ  per-requester transfer request, level
tx_data_i  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k]
grant_o  out  NUM_REQ  one-hot grant, held for the whole transaction
done_o  out  NUM_REQ  one-hot, one-cycle pulse on successful completion
err_o  out  NUM_REQ  one-hot, one-cycle pulse on timeout abort
m_tx_en_o  out  1  one-cycle start pulse to the SPI master
m_tx_data_o  out  8  latched byte to the master, sent MSB first by the master
m_abort_o  out  1  one-cycle abort pulse to the master
m_busy_i  in  1  master not in idle
m_done_i  in  1  master one-cycle completion pulse
slave_sel_o  out  NUM_REQ  one-hot slave select, equal to grant_o

Behaviour:
- Clock and reset:
  - Single clock, clk. Reset rst is asynchronous, active-high.
  - On reset: state=IDLE; grant_o, done_o, err_o, slave_sel_o=0; m_tx_en_o=0; m_abort_o=0; m_tx_data_o=8'h00; rr_ptr=0; gap and timeout counters=0.
  - Reset mid-transaction: all outputs return to reset values immediately. No done_o or err_o pulse is emitted for the interrupted transfer.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - If req_i!=0 at a clock edge, register the winner and go to ISSUE.
  - Winner = first set bit of req_i searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - At the same edge: grant_o=slave_sel_o=onehot(winner); m_tx_data_o=tx_data_i[winner].
  - Latency: grant_o rises 1 cycle after req_i is sampled.
- ISSUE:
  - If m_busy_i=0, pulse m_tx_en_o for exactly one cycle and go to WAIT_DONE. Otherwise stay in ISSUE with m_tx_en_o=0.
  - The timeout counter clears on entry to WAIT_DONE.
- WAIT_DONE:
  - On m_done_i=1: pulse done_o[winner] for one cycle, clear grant_o and slave_sel_o, set rr_ptr=(winner+1) mod NUM_REQ, go to GAP.
  - Otherwise the counter increments. When it equals TIMEOUT_CYC-1 without m_done_i: pulse err_o[winner] and m_abort_o for one cycle, clear grant_o, advance rr_ptr as above, go to GAP.
  - If m_done_i and the timeout coincide, done wins: no error is reported.
- GAP:
  - Count GAP_CYC cycles with all grants low, then return to IDLE.
  - Requests are not evaluated during GAP.
- Requester rules:
  - Requester data is sampled only at grant. Later changes to tx_data_i do not affect the transfer in flight.
  - Dropping req_i while granted does not cancel the transfer; it completes and done_o is still pulsed.
  - The requester must drop req_i on done_o or err_o; otherwise it re-enters arbitration at lowest priority.
- m_done_i outside WAIT_DONE is ignored.
- Counter widths: $clog2(TIMEOUT_CYC+1) and $clog2(GAP_CYC+1). The pointer is $clog2(NUM_REQ) wide and wraps from NUM_REQ-1 to 0 explicitly, including for non-power-of-two NUM_REQ.

Decomposition:
- Package spi_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT_DONE, GAP}
  - localparam SPI_BYTE_W=8
- Sub-module spi_rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: valid, winner index.
  - Instantiated once. Everything else (FSM, counters, latches) lives in the top.

Test Plan:
- Single requester: req_i=4'b0010, tx_data_i[15:8]=8'hA3, master model returns m_done_i 70 cycles after m_tx_en_o -> grant_o=4'b0010 one cycle after req; m_tx_data_o=8'hA3; exactly one m_tx_en_o pulse; done_o=4'b0010 for one cycle; 4 idle cycles before any new grant.
- Round-robin fairness: req_i=4'b1111 held continuously -> grant order 0,1,2,3,0, each grant separated by GAP_CYC low cycles.
- Timeout: master never asserts m_done_i; TIMEOUT_CYC=255 -> err_o[winner] and m_abort_o pulse together, done_o stays 0, rr_ptr advances.
- Busy master: m_busy_i=1 for 10 cycles after grant -> m_tx_en_o held low until m_busy_i falls, then pulses for one cycle.
- Coincidence and data hold: m_done_i on the final timeout cycle -> done_o pulses, err_o=0. Change tx_data_i after grant -> m_tx_data_o unchanged.
- Async reset: assert rst mid-WAIT_DONE, between clock edges -> all outputs 0 immediately, no done_o or err_o pulse; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI request arbiter.
//   arb_state_t : arbiter FSM state encoding
//   SPI_BYTE_W  : width of one SPI transfer byte
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per requester
//   rr_ptr : index with highest priority this round
//   valid  : at least one request is set
//   winner : first set request at or above rr_ptr, wrapping modulo NUM_REQ
module spi_rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    // Scan from the lowest priority offset down, so the last hit
    // (smallest offset from rr_ptr) is the one that sticks.
    always_comb begin
        int j;
        valid  = 1'b0;
        winner = '0;
        j      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) begin
                valid  = 1'b1;
                winner = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one byte-wide SPI master among NUM_REQ
// requesters. Latches the winner's byte, starts the master, waits for
// completion or timeout, then holds chip select idle for GAP_CYC cycles.
//   clk, rst       : clock, asynchronous active-high reset
//   req_i          : per-requester level request
//   tx_data_i      : per-requester byte, requester k at [8k+7:8k]
//   grant_o        : one-hot grant, held for the whole transaction
//   done_o / err_o : one-hot one-cycle completion / timeout pulses
//   m_tx_en_o      : one-cycle start pulse to the master
//   m_tx_data_o    : byte latched at grant
//   m_abort_o      : one-cycle abort pulse on timeout
//   m_busy_i       : master not idle
//   m_done_i       : master completion pulse
//   slave_sel_o    : one-hot slave select, mirrors grant_o
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [SPI_BYTE_W*NUM_REQ-1:0] tx_data_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [NUM_REQ-1:0]            err_o,
    output logic                          m_tx_en_o,
    output logic [SPI_BYTE_W-1:0]         m_tx_data_o,
    output logic                          m_abort_o,
    input  logic                          m_busy_i,
    input  logic                          m_done_i,
    output logic [NUM_REQ-1:0]            slave_sel_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [NUM_REQ-1:0]     err_q, err_d;
    logic                   tx_en_q, tx_en_d;
    logic                   abort_q, abort_d;
    logic [SPI_BYTE_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   finish;

    spi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req_i),
        .rr_ptr (rr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        tx_en_d   = 1'b0;
        abort_d   = 1'b0;
        data_d    = data_q;
        rr_d      = rr_q;
        win_d     = win_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        finish    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_idx;
                    grant_d = onehot(pick_idx);
                    data_d  = tx_data_i[int'(pick_idx)*SPI_BYTE_W +: SPI_BYTE_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!m_busy_i) begin
                    tx_en_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A completion on the last timeout cycle takes priority.
                if (m_done_i) begin
                    done_d = grant_q;
                    finish = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = grant_q;
                    abort_d = 1'b1;
                    finish  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                if (finish) begin
                    grant_d   = '0;
                    rr_d      = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                // GAP_CYC cycles here; requests are sampled again in IDLE.
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            tx_en_q   <= 1'b0;
            abort_q   <= 1'b0;
            data_q    <= '0;
            rr_q      <= '0;
            win_q     <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tx_en_q   <= tx_en_d;
            abort_q   <= abort_d;
            data_q    <= data_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign grant_o     = grant_q;
    assign slave_sel_o = grant_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign m_tx_en_o   = tx_en_q;
    assign m_abort_o   = abort_q;
    assign m_tx_data_o = data_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: expected grants are queued when a
// request is driven, compared on grant rise, then compared again on the
// done/err pulse. A simple master model answers m_tx_en_o after a
// programmable delay (0 = never answers).
module tb_spi_req_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 255;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
        logic       is_err;
    } exp_t;

    logic        clk, rst;
    logic [3:0]  req_i;
    logic [31:0] tx_data_i;
    logic [3:0]  grant_o, done_o, err_o, slave_sel_o;
    logic        m_tx_en_o, m_abort_o, m_busy_i, m_done_i;
    logic [7:0]  m_tx_data_o;

    int checks = 0, errors = 0;
    int grant_cnt = 0, cmpl_cnt = 0;
    int done_delay = 5, mcnt = 0, rr_m = 0;
    int tx_en_cnt = 0, low_cnt = 0;
    logic have_prev = 1'b0, gap_exact = 1'b0;
    logic [3:0] prev_grant = '0;
    exp_t exp_q[$], pend_q[$];
    exp_t mon_e;

    spi_req_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .tx_data_i(tx_data_i),
        .grant_o(grant_o), .done_o(done_o), .err_o(err_o),
        .m_tx_en_o(m_tx_en_o), .m_tx_data_o(m_tx_data_o), .m_abort_o(m_abort_o),
        .m_busy_i(m_busy_i), .m_done_i(m_done_i), .slave_sel_o(slave_sel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return 0;
    endfunction

    task automatic push_exp(input logic [3:0] r, input logic is_err);
        exp_t e;
        int   w;
        w        = model_pick(r, rr_m);
        e.grant  = 4'b0001 << w;
        e.data   = tx_data_i[w*8 +: 8];
        e.is_err = is_err;
        exp_q.push_back(e);
        rr_m = (w + 1) % NUM_REQ;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (grant_cnt < n && k < 1000) begin step(); k++; end
        chk("grant_wait", 32'(grant_cnt >= n), 1);
    endtask

    task automatic wait_cmpl(input int n);
        int k = 0;
        while (cmpl_cnt < n && k < 1000) begin step(); k++; end
        chk("cmpl_wait", 32'(cmpl_cnt >= n), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_sel"},   slave_sel_o, 0);
        chk({tag, "_done"},  done_o, 0);
        chk({tag, "_err"},   err_o, 0);
        chk({tag, "_txen"},  m_tx_en_o, 0);
        chk({tag, "_abort"}, m_abort_o, 0);
        chk({tag, "_data"},  m_tx_data_o, 0);
    endtask

    // Single-request transaction: request dropped as soon as it is granted.
    task automatic run_one(input logic [3:0] r, input int delay, input logic is_err);
        int g, c;
        g = grant_cnt; c = cmpl_cnt;
        done_delay = delay;
        push_exp(r, is_err);
        req_i = r;
        wait_grants(g + 1);
        req_i = '0;
        wait_cmpl(c + 1);
        repeat (GAP_CYC + 2) step();
    endtask

    // Master model: m_done_i pulses done_delay cycles after the start pulse.
    initial begin
        m_done_i = 1'b0;
        forever begin
            @(negedge clk);
            m_done_i = 1'b0;
            if (rst) mcnt = 0;
            else if (m_tx_en_o && done_delay > 0) mcnt = done_delay;
            else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) m_done_i = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_grant = '0;
            tx_en_cnt  = 0;
            low_cnt    = 0;
            have_prev  = 1'b0;
        end else begin
            if (grant_o != 0 && prev_grant == 0) begin
                if (have_prev) begin
                    if (gap_exact) chk("gap_len", low_cnt, GAP_CYC + 1);
                    else           chk("gap_min", 32'(low_cnt >= GAP_CYC + 1), 1);
                end
                if (exp_q.size() == 0) chk("unexp_grant", grant_o, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("grant",   grant_o,     mon_e.grant);
                    chk("sel",     slave_sel_o, mon_e.grant);
                    chk("tx_data", m_tx_data_o, mon_e.data);
                    pend_q.push_back(mon_e);
                end
                tx_en_cnt = 0;
                grant_cnt++;
            end
            if (m_tx_en_o) tx_en_cnt++;
            if (done_o != 0 || err_o != 0) begin
                if (pend_q.size() == 0) chk("unexp_cmpl", {done_o, err_o}, 0);
                else begin
                    mon_e = pend_q.pop_front();
                    chk("done",      done_o,      mon_e.is_err ? 4'b0 : mon_e.grant);
                    chk("err",       err_o,       mon_e.is_err ? mon_e.grant : 4'b0);
                    chk("abort",     m_abort_o,   mon_e.is_err);
                    chk("tx_en_cnt", tx_en_cnt,   1);
                    chk("grant_clr", grant_o,     0);
                    chk("data_hold", m_tx_data_o, mon_e.data);
                end
                low_cnt   = 0;
                have_prev = 1'b1;
                cmpl_cnt++;
            end else if (m_abort_o) begin
                chk("stray_abort", m_abort_o, 0);
            end
            if (grant_o == 0) low_cnt++;
            prev_grant = grant_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int g, c;
        rst = 1'b1; req_i = '0; m_busy_i = 1'b0;
        tx_data_i = 32'h44_33_22_11;
        repeat (3) step();
        chk_reset_outputs("rst");
        rst = 1'b0;
        step();

        // Fairness: all requesting, expect 0,1,2,3,0 with exact gaps.
        gap_exact  = 1'b1;
        done_delay = 5;
        g = grant_cnt; c = cmpl_cnt;
        for (int i = 0; i < 5; i++) push_exp(4'b1111, 1'b0);
        req_i = 4'b1111;
        wait_grants(g + 5);
        req_i = '0;
        wait_cmpl(c + 5);
        gap_exact = 1'b0;
        repeat (GAP_CYC + 2) step();

        // Single requester, data change after grant, req dropped mid-flight.
        tx_data_i  = 32'h44_33_A3_11;
        done_delay = 70;
        g = grant_cnt; c = cmpl_cnt;
        push_exp(4'b0010, 1'b0);
        req_i = 4'b0010;
        step();
        chk("grant_lat", grant_o, 4'b0010);
        tx_data_i = 32'hFFFF_FFFF;
        req_i     = '0;
        step();
        chk("data_after_chg", m_tx_data_o, 8'hA3);
        wait_cmpl(c + 1);
        repeat (GAP_CYC + 2) step();
        tx_data_i = 32'h44_33_22_11;

        // Busy master holds off the start pulse.
        m_busy_i   = 1'b1;
        done_delay = 6;
        g = grant_cnt; c = cmpl_cnt;
        push_exp(4'b0100, 1'b0);
        req_i = 4'b0100;
        wait_grants(g + 1);
        req_i = '0;
        for (int i = 0; i < 10; i++) begin
            chk("busy_hold", m_tx_en_o, 0);
            step();
        end
        m_busy_i = 1'b0;
        step();
        chk("txen_after_busy", m_tx_en_o, 1);
        wait_cmpl(c + 1);
        repeat (GAP_CYC + 2) step();

        // Timeout on requester 3, then rr pointer must have wrapped to 0.
        run_one(4'b1000, 0, 1'b1);
        // done on the final timeout cycle wins
        run_one(4'b1001, TIMEOUT_CYC - 1, 1'b0);
        // done one cycle too late: error, late done ignored in GAP
        run_one(4'b0011, TIMEOUT_CYC, 1'b1);

        // Async reset in WAIT_DONE, between clock edges.
        done_delay = 0;
        g = grant_cnt;
        push_exp(4'b0100, 1'b0);
        req_i = 4'b0100;
        wait_grants(g + 1);
        repeat (20) step();
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        exp_q.delete();
        pend_q.delete();
        rr_m  = 0;
        req_i = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Arbitration restarts at requester 0.
        run_one(4'b1111, 3, 1'b0);
        chk("exp_q_empty",  exp_q.size(),  0);
        chk("pend_q_empty", pend_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
